fetch_prefetch_queue: RTL and testbench

//  Instruction-fetch front end feeding the IF/ID pipeline register of the pipelined RISC-V core.

---
 rtl/fetch_prefetch_queue.sv | 104 ++++++++++
 tb/tb_fetch_prefetch_queue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: issues sequential fetches under a credit limit, buffers in-order
// responses in a small FIFO and presents {instr, pc, pc+4} to decode; redirects flush and drop stale data.
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] stale;
    logic [CW:0]   credits_used;
    logic [31:0]   redirect_aligned;
    logic          accept;
    logic          push;
    logic          pop;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        credits_used     = {1'b0, count} + {1'b0, outstanding};
        redirect_aligned = {redirect_pc[31:2], 2'b00};
        // Gated by rst so the request strobe reads 0 while reset is held.
        imem_req_valid   = rst && !redirect_valid && (credits_used < (CW + 1)'(DEPTH));
        imem_req_addr    = fetch_pc;
        accept           = imem_req_valid && imem_req_ready;
        out_valid        = (count != '0);
        push             = imem_rsp_valid && (stale == '0) && !redirect_valid;
        pop              = out_valid && !stall && !redirect_valid;
        out_instr        = out_valid ? instr_mem[rd_ptr] : '0;
        out_pc           = out_valid ? pc_mem[rd_ptr] : '0;
        out_pc_plus4     = out_valid ? pc_mem[rd_ptr] + 32'd4 : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            stale       <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_aligned;
            resp_pc     <= redirect_aligned;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding - CW'(imem_rsp_valid);
            // The in-flight count already includes older stale fetches, so after a redirect
            // every fetch still in flight is stale; this also keeps back-to-back redirects exact.
            stale       <= outstanding - CW'(imem_rsp_valid);
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
                wr_ptr  <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count       <= count + CW'(push) - CW'(pop);
            outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (stale != '0)) begin
                stale <= stale - 1'b1;
            end
        end
    end

    // NOTE: FIFO storage is not reset; out_valid and the output gating hide its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_rsp_data;
            pc_mem[wr_ptr]    <= resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench: latency-configurable in-order memory model plus a scoreboard of expected
// decode outputs, driven through directed phases (stall, redirect, backpressure, reset) and a random phase.
module tb_fetch_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mem_req_t;

    mem_req_t    mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_fetch;
    int          epoch;
    int          cyc;
    int          lat;
    int          checks;
    int          errors;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[17:2] ^ 16'h5A3C, ~addr[17:2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, let the memory answer, then compare
    // the DUT against the scoreboard before the rising edge commits the cycle.
    task automatic step(input logic redir, input logic [31:0] rpc, input logic stl, input logic rdy);
        mem_req_t    ent;
        logic        rsp_now;
        logic        exp_rv;
        logic [31:0] head;
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc    = rpc;
        stall          = stl;
        imem_req_ready = rdy;
        rsp_now        = 1'b0;
        ent            = '{addr: 32'h0, due: 0, epoch: -1};
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            ent            = mem_q.pop_front();
            rsp_now        = 1'b1;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(ent.addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        exp_rv = !redir && ((exp_q.size() + mem_q.size() + int'(rsp_now)) < DEPTH);
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (imem_req_valid) check("req_addr", imem_req_addr, exp_fetch);
        check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
        if (out_valid && exp_q.size() > 0) begin
            head = exp_q[0];
            check("out_pc", out_pc, head);
            check("out_pc_plus4", out_pc_plus4, head + 32'd4);
            check("out_instr", out_instr, mem_word(head));
            if (!stl && !redir) void'(exp_q.pop_front());
        end
        if (redir) begin
            exp_q.delete();
            epoch++;
            exp_fetch = {rpc[31:2], 2'b00};
        end else begin
            if (rsp_now && ent.epoch == epoch) exp_q.push_back(mem_word(ent.addr) == mem_word(exp_fetch) ? ent.addr : ent.addr);
            if (imem_req_valid && rdy) begin
                mem_q.push_back('{addr: imem_req_addr, due: cyc + lat, epoch: epoch});
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n, input logic stl, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, stl, rdy);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'h0);
        check({tag, "_out_valid"}, {31'b0, out_valid}, 32'h0);
        check({tag, "_out_instr"}, out_instr, 32'h0);
        check({tag, "_out_pc"}, out_pc, 32'h0);
        check({tag, "_out_pc_plus4"}, out_pc_plus4, 32'h0);
    endtask

    task automatic release_reset();
        mem_q.delete();
        exp_q.delete();
        epoch++;
        exp_fetch = RESET_PC;
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        epoch          = 0;
        cyc            = 0;
        lat            = 1;
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = 1'b0;
        #1;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        release_reset();

        // T1: single-cycle memory, free-running decode.
        lat = 1;
        run(12, 1'b0, 1'b1);

        // T2: decode stalled long enough to fill the FIFO, then released.
        run(10, 1'b1, 1'b1);
        check("t2_fifo_full", exp_q.size(), DEPTH);
        run(10, 1'b0, 1'b1);

        // T3: three-cycle memory with fetches in flight, redirect to 0x100.
        lat = 3;
        run(4, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0100, 1'b0, 1'b1);
        run(12, 1'b0, 1'b1);

        // T4: redirect coinciding with a response and a pop, then with a stalled decode.
        lat = 1;
        run(6, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0200, 1'b0, 1'b1);
        run(6, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0280, 1'b1, 1'b1);
        run(6, 1'b0, 1'b1);

        // Back-to-back redirects (last wins), unaligned target, address wrap at 2^32.
        lat = 2;
        run(4, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0300, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0503, 1'b0, 1'b1);
        run(8, 1'b0, 1'b1);
        step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
        run(10, 1'b0, 1'b1);

        // T5: memory backpressure holds the request address while the FIFO drains.
        lat = 1;
        run(5, 1'b0, 1'b0);
        run(10, 1'b0, 1'b1);

        // T6: asynchronous reset asserted mid-cycle during streaming.
        run(3, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst            = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check_outputs_zero("t6_async");
        repeat (2) @(posedge clk);
        release_reset();
        run(8, 1'b0, 1'b1);

        // Random mix of stalls, backpressure, latency and redirects.
        for (int ph = 0; ph < 8; ph++) begin
            lat = $urandom_range(1, 3);
            for (int i = 0; i < 40; i++) begin
                step(($urandom_range(0, 19) == 0), {$urandom_range(0, 16'hFFFF), 2'b00} << 2,
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0));
            end
        end
        run(12, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
